rc4_prga_engine: RTL and testbench

Parametrised RC4 keystream generator and decryptor for the RC4 breaker datapath. It runs the RC4 PRGA loop over an externally held, already key-scheduled S array through a single-port RAM interface, swapping S entries in place. It reads ciphertext bytes from a message ROM, XORs each with the keystream, and writes plaintext to an output RAM. An optional plaintext check aborts early on the first byte outside {a–z, space}, so the key-search controller can reject a candidate key without decrypting the whole message.

---
 rtl/rc4_pkg.sv | 27 ++
 rtl/rc4_prga_engine.sv | 142 ++++++++++++++
 tb/tb_rc4_prga_engine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 types and helpers for the KSA, PRGA engine and key-search controller.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC,
    ST_RD_I,
    ST_LAT_I,
    ST_RD_J,
    ST_LAT_J,
    ST_WR_I,
    ST_WR_J,
    ST_RD_F,
    ST_LAT_F,
    ST_OUT,
    ST_FIN
  } prga_state_t;

  localparam logic [7:0] CH_A  = 8'h61;
  localparam logic [7:0] CH_Z  = 8'h7A;
  localparam logic [7:0] CH_SP = 8'h20;

  function automatic logic is_plain_char(input logic [7:0] c);
    return ((c >= CH_A) && (c <= CH_Z)) || (c == CH_SP);
  endfunction

endpackage

// File: rtl/rc4_prga_engine.sv
// RC4 PRGA over an external single-port S RAM; decrypts the message ROM into the output RAM.
// Fixed 10 cycles per byte; optional early abort on the first byte outside {a-z, space}.
module rc4_prga_engine
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int DATA_W  = 8,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              check_en,
  output logic              busy,
  output logic              done,
  output logic              key_ok,
  output logic [MSG_AW-1:0] fail_idx,
  output logic [DATA_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_we,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [MSG_AW-1:0] msg_addr,
  input  logic [DATA_W-1:0] msg_rdata,
  output logic [MSG_AW-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_we
);

  localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

  prga_state_t       r_state;
  logic [DATA_W-1:0] r_i;
  logic [DATA_W-1:0] r_j;
  logic [DATA_W-1:0] r_si;
  logic [DATA_W-1:0] r_sj;
  logic [MSG_AW-1:0] r_k;
  logic              r_chk;
  logic              r_pass;
  logic [DATA_W-1:0] w_plain;

  assign w_plain = s_rdata ^ msg_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_si     <= '0;
      r_sj     <= '0;
      r_k      <= '0;
      r_chk    <= 1'b0;
      r_pass   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      key_ok   <= 1'b0;
      fail_idx <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_we     <= 1'b0;
      msg_addr <= '0;
      out_addr <= '0;
      out_data <= '0;
      out_we   <= 1'b0;
    end else begin
      done   <= 1'b0;
      s_we   <= 1'b0;
      out_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_INC;
            busy     <= 1'b1;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_chk    <= check_en;
            key_ok   <= 1'b0;
            fail_idx <= '0;
          end
        end
        ST_INC: begin
          r_i     <= r_i + 1'b1;
          s_addr  <= r_i + 1'b1;
          r_state <= ST_RD_I;
        end
        ST_RD_I:  r_state <= ST_LAT_I;
        ST_LAT_I: begin
          r_si    <= s_rdata;
          r_j     <= r_j + s_rdata;
          s_addr  <= r_j + s_rdata;
          r_state <= ST_RD_J;
        end
        ST_RD_J:  r_state <= ST_LAT_J;
        // Swap: S[i] <= sj in WR_I, then S[j] <= si in WR_J; i == j rewrites the same value twice.
        ST_LAT_J: begin
          r_sj    <= s_rdata;
          s_addr  <= r_i;
          s_wdata <= s_rdata;
          s_we    <= 1'b1;
          r_state <= ST_WR_I;
        end
        ST_WR_I: begin
          s_addr  <= r_j;
          s_wdata <= r_si;
          s_we    <= 1'b1;
          r_state <= ST_WR_J;
        end
        ST_WR_J: begin
          s_addr   <= r_si + r_sj;
          msg_addr <= r_k;
          r_state  <= ST_RD_F;
        end
        ST_RD_F:  r_state <= ST_LAT_F;
        ST_LAT_F: begin
          out_addr <= r_k;
          out_data <= w_plain;
          out_we   <= 1'b1;
          r_pass   <= !r_chk || is_plain_char(8'(w_plain));
          r_state  <= ST_OUT;
        end
        ST_OUT: begin
          if (r_pass && (r_k != LAST_K)) begin
            r_k     <= r_k + 1'b1;
            r_state <= ST_INC;
          end else begin
            r_state <= ST_FIN;
          end
        end
        // Only a failing byte stops the loop early, so r_pass alone tells pass vs abort.
        ST_FIN: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          key_ok   <= r_pass;
          fail_idx <= r_pass ? '0 : r_k;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Randomized and directed bench for rc4_prga_engine against a plain RC4 reference model.
module tb_rc4_prga_engine;

  localparam int MSG_LEN = 9;
  localparam int DATA_W  = 8;
  localparam int MSG_AW  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              check_en;
  logic              busy, done, key_ok, s_we, out_we;
  logic [MSG_AW-1:0] fail_idx, msg_addr, out_addr;
  logic [DATA_W-1:0] s_addr, s_wdata, s_rdata, msg_rdata, out_data;

  rc4_prga_engine #(.MSG_LEN(MSG_LEN), .DATA_W(DATA_W), .MSG_AW(MSG_AW)) dut (
    .clk(clk), .reset(reset), .start(start), .check_en(check_en),
    .busy(busy), .done(done), .key_ok(key_ok), .fail_idx(fail_idx),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_rdata(s_rdata),
    .msg_addr(msg_addr), .msg_rdata(msg_rdata),
    .out_addr(out_addr), .out_data(out_data), .out_we(out_we)
  );

  always #5 clk = ~clk;

  // Memory models: S RAM (loadable), message ROM, output write log.
  logic [7:0] s_mem  [256];
  logic [7:0] s_init [256];
  logic [7:0] msg_rom[16];
  logic       ld = 1'b0;
  logic [MSG_AW-1:0] wr_addr_q[$];
  logic [7:0]        wr_dat_q[$];
  int done_cnt = 0;

  always @(posedge clk) begin
    if (ld) s_mem <= s_init;
    else if (s_we) s_mem[s_addr] <= s_wdata;
    s_rdata   <= s_mem[s_addr];
    msg_rdata <= msg_rom[msg_addr];
    if (out_we) begin
      wr_addr_q.push_back(out_addr);
      wr_dat_q.push_back(out_data);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: straight RC4 PRGA on a byte array.
  logic [7:0] ref_s  [256];
  logic [7:0] ref_enc[16];
  logic [7:0] ref_out[16];
  logic [7:0] pt     [16];
  int ref_nw, ref_fidx;
  bit ref_ok;

  task automatic rc4_ref(input bit chk_on);
    logic [7:0] i, j, si, sj, ks;
    i = 0; j = 0; ref_nw = 0; ref_ok = 1; ref_fidx = 0;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = i + 8'd1;
      si = ref_s[i];
      j = j + si;
      sj = ref_s[j];
      ref_s[i] = sj;
      ref_s[j] = si;
      ks = ref_s[8'(si + sj)];
      ref_out[k] = ks ^ ref_enc[k];
      ref_nw++;
      if (chk_on && !(ref_out[k] inside {[8'h61:8'h7A], 8'h20})) begin
        ref_ok = 0;
        ref_fidx = k;
        break;
      end
    end
  endtask

  task automatic make_enc_from_pt();
    for (int x = 0; x < 256; x++) ref_s[x] = s_init[x];
    for (int k = 0; k < 16; k++) ref_enc[k] = 8'h00;
    rc4_ref(1'b0);
    for (int k = 0; k < 16; k++) msg_rom[k] = (k < MSG_LEN) ? (pt[k] ^ ref_out[k]) : 8'h00;
  endtask

  task automatic load_s();
    @(negedge clk); ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask

  int wr_base;

  task automatic run_test(input string name, input bit chk_on, input bit poke);
    int n, exp_n, d0, sbad;
    load_s();
    for (int x = 0; x < 256; x++) ref_s[x] = s_init[x];
    for (int k = 0; k < 16; k++) ref_enc[k] = msg_rom[k];
    rc4_ref(chk_on);
    exp_n = 10 * ref_nw + 1;
    wr_base = wr_addr_q.size();
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; check_en = chk_on;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (n == 1) chk({name, ".busy"}, busy, 1'b1);
      if (poke && (n == 5 || n == exp_n - 1)) start = 1'b1;
      if (done) break;
    end
    start = 1'b0;
    chk({name, ".cycles"}, n, exp_n);
    chk({name, ".key_ok"}, key_ok, ref_ok);
    chk({name, ".fail_idx"}, fail_idx, ref_ok ? 0 : ref_fidx);
    repeat (3) @(posedge clk);
    #1;
    chk({name, ".nwrites"}, wr_addr_q.size() - wr_base, ref_nw);
    for (int k = 0; k < ref_nw && (wr_base + k) < wr_addr_q.size(); k++) begin
      chk({name, ".out_addr"}, wr_addr_q[wr_base + k], k);
      chk({name, ".out_data"}, wr_dat_q[wr_base + k], ref_out[k]);
    end
    sbad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) sbad++;
    chk({name, ".s_final"}, sbad, 0);
    chk({name, ".one_done"}, done_cnt - d0, 1);
    chk({name, ".idle"}, busy, 1'b0);
    chk({name, ".hold_ok"}, key_ok, ref_ok);
  endtask

  logic [7:0] key3[3];
  logic [7:0] exp_txt[9];
  logic [7:0] enc_v[9];

  initial begin
    reset = 1'b1; start = 1'b0; check_en = 1'b0;
    for (int k = 0; k < 16; k++) msg_rom[k] = 8'h00;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.outs", {done, key_ok, s_we, out_we, fail_idx, s_addr, s_wdata, msg_addr, out_addr, out_data}, 0);
    @(negedge clk); reset = 1'b0;

    // Identity S, abort on byte 1 (0x00 ^ 5 = 0x05).
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    msg_rom[0] = 8'h63; msg_rom[1] = 8'h00;
    for (int k = 2; k < MSG_LEN; k++) msg_rom[k] = 8'($urandom_range(0, 255));
    run_test("ident_abort", 1'b1, 1'b0);
    chk("ident.cycles_const", 10 * ref_nw + 1, 21);
    chk("ident.out0", wr_dat_q[wr_base], 8'h61);
    chk("ident.out1", wr_dat_q[wr_base + 1], 8'h05);
    chk("ident.fidx", fail_idx, 1);
    chk("ident.s2", s_mem[2], 8'h03);
    chk("ident.s3", s_mem[3], 8'h02);

    // Identity S, full 'a' message.
    for (int k = 0; k < 16; k++) pt[k] = 8'h61;
    make_enc_from_pt();
    chk("ident.enc0", msg_rom[0], 8'h63);
    chk("ident.enc1", msg_rom[1], 8'h64);
    run_test("ident_full", 1'b1, 1'b1);

    // Key "Key" vector.
    key3 = '{8'h4B, 8'h65, 8'h79};
    exp_txt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    enc_v   = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    begin
      logic [7:0] jj, t;
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
      jj = 0;
      for (int x = 0; x < 256; x++) begin
        jj = jj + s_init[x] + key3[x % 3];
        t = s_init[x]; s_init[x] = s_init[jj]; s_init[jj] = t;
      end
    end
    for (int k = 0; k < MSG_LEN; k++) msg_rom[k] = enc_v[k];
    run_test("key_nochk", 1'b0, 1'b0);
    for (int k = 0; k < MSG_LEN; k++) chk("key.txt", wr_dat_q[wr_base + k], exp_txt[k]);
    chk("key.ok", key_ok, 1'b1);
    run_test("key_chk", 1'b1, 1'b0);
    chk("key_chk.byte0", wr_dat_q[wr_base], 8'h50);
    chk("key_chk.ok", key_ok, 1'b0);

    // Random permutations and plaintexts.
    for (int it = 0; it < 6; it++) begin
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
      for (int x = 255; x > 0; x--) begin
        int r; logic [7:0] t;
        r = $urandom_range(0, x);
        t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
      end
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 15) == 0) pt[k] = 8'($urandom_range(0, 255));
        else if ($urandom_range(0, 5) == 0) pt[k] = 8'h20;
        else pt[k] = 8'($urandom_range(8'h61, 8'h7A));
      end
      make_enc_from_pt();
      run_test("rand", 1'($urandom_range(0, 1)), it == 0);
    end

    // Reset in mid-run, then a clean run.
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int k = 0; k < 16; k++) pt[k] = 8'h7A;
    make_enc_from_pt();
    load_s();
    @(negedge clk); start = 1'b1; check_en = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (13) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.outs", {done, key_ok, s_we, out_we, fail_idx, s_addr, s_wdata, msg_addr, out_addr, out_data}, 0);
    @(negedge clk); reset = 1'b0;
    run_test("after_rst", 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
